instr_mem_fetch: RTL
====================

// Module: instr_mem_fetch
// PURPOSE
//  Parametrised RISC-V instruction memory with a synchronous read, a valid/ready fetch port and a word-wide program-load port.
//  - Sits between the PC/fetch stage and the decoder.
//  - Clears itself to a reset instruction after every reset.
//  - Flags misaligned and out-of-range fetches instead of returning garbage.
// PARAMETERS
//  DEPTH_WORDS  256           number of 32-bit words; power of two, >= 2
//  BASE_ADDR    32'h0000_0000 byte address of word 0; word-aligned
//  RESET_WORD   32'h0000_0013 fill value written during init (addi x0,x0,0)
// PORTS
//  clk          in   1   single clock; all state changes on posedge
//  reset        in   1   synchronous, active-high
//  req_valid    in   1   fetch request present
//  req_ready    out  1   fetch request accepted when req_valid & req_ready
//  req_pc       in   32  byte address of the instruction to fetch
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   response consumed when rsp_valid & rsp_ready
//  rsp_instr    out  32  fetched instruction, little-endian word
//  rsp_fault    out  2   00 ok, 01 misaligned, 10 out of range, 11 parity error
//  prog_we      in   1   program-load word write strobe
//  prog_addr    in   32  byte address of the program-load write
//  prog_data    in   32  program-load write data
//  init_done    out  1   high once the init sweep has finished
// BEHAVIOUR
//  Reset (while reset=1 on a posedge):
//  - rsp_valid=0, rsp_instr=0, rsp_fault=00, init_done=0, req_ready=0.
//  - Init counter cleared; state goes to INIT.
//  INIT:
//  - One word written per cycle, index 0..DEPTH_WORDS-1, each with RESET_WORD.
//  - After the last write, state goes to RUN and init_done=1 on the next edge.
//    init_done first rises on the DEPTH_WORDS-th posedge after reset deasserts.
//  - prog_we and req_valid are ignored in INIT.
//  - Reset during INIT restarts the sweep from index 0.
//  RUN:
//  - req_ready = init_done & (!rsp_valid | rsp_ready), combinational.
//  - Latency 1: a request accepted at edge N gives rsp_valid=1 after edge N.
//    Throughput is one fetch per cycle while rsp_ready=1.
//  - While rsp_valid=1 & rsp_ready=0, rsp_instr and rsp_fault hold stable and no new request is accepted.
//  - rsp_valid clears after a consuming edge with no new request accepted.
//  Fault check on the accepted req_pc (priority misaligned > range):
//  - req_pc[1:0]!=0 -> fault 01.
//  - (req_pc-BASE_ADDR) >= 4*DEPTH_WORDS, unsigned 32-bit with wrap, so a pc below BASE_ADDR also faults -> fault 10.
//  - On any fault, rsp_instr=0 and no memory read is performed.
//  - Word index = (req_pc-BASE_ADDR)>>2.
//  Program load:
//  - Write happens at the posedge with prog_we=1, in RUN only.
//  - Misaligned or out-of-range prog_addr: the write is silently dropped.
//  - A write and a fetch of the same word in the same cycle: the fetch returns the old contents (read-before-write).
//  Reset in RUN:
//  - Any pending response is dropped (rsp_valid=0 after that edge).
//  - Memory is refilled by INIT, so loaded programs are lost.
// CONFIGURATION
//  IMEM_PARITY_EN defined:
//  - Each word stores an extra even-parity bit over its 32 data bits, written on both init and program-load writes.
//  - An in-range, aligned fetch whose stored parity mismatches gives fault 11; rsp_instr still carries the raw stored data.
//  IMEM_PARITY_EN undefined:
//  - 32-bit storage only; fault code 11 is never produced.
// TESTING
//  1 Release reset, DEPTH_WORDS=256: init_done rises on the 256th edge after release.
//    Then fetch 0x0 -> rsp_instr=0x00000013, fault 00.
//  2 prog_we at 0x0 with data 0x00940333, then fetch 0x0:
//    rsp_valid one cycle after accept, instr 0x00940333, fault 00.
//  3 Fetch 0x0, 0x4, 0x8 back-to-back with rsp_ready=1: three responses on consecutive cycles.
//    Then hold rsp_ready=0 for 3 cycles: response stable, req_ready=0.
//  4 Fetch 0x2 -> fault 01, instr 0.
//    Fetch 0x400 (DEPTH 256, BASE 0) -> fault 10, instr 0.
//    Fetch 0x402 -> fault 01.
//  5 Same cycle: prog_we to 0x10 with 0xDEADBEEF and fetch 0x10 -> old 0x00000013.
//    Next fetch of 0x10 -> 0xDEADBEEF.
//  6 Assert reset while a response is stalled, and again mid-INIT:
//    rsp_valid=0 after the edge, init restarts and takes the full 256 cycles.
//    With IMEM_PARITY_EN, flip one stored bit by backdoor force, then fetch that word -> fault 11.

Source files
------------

// File: rtl/instr_mem_fetch_if.sv
// Fetch / program-load bus between the PC stage and the instruction memory.
// The master side is the fetch stage and the program loader; the slave side is
// instr_mem_fetch.
interface instr_mem_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        init_done;

    modport master (
        output req_valid, req_pc, rsp_ready, prog_we, prog_addr, prog_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault, init_done
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready, prog_we, prog_addr, prog_data,
        output req_ready, rsp_valid, rsp_instr, rsp_fault, init_done
    );
endinterface

// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: RISC-V instruction memory with a one-cycle valid/ready fetch
// port and a word-wide program-load port. After every reset the array is swept
// with RESET_WORD (one word per cycle) before fetches are accepted. Misaligned
// and out-of-range fetches return a fault code with a zero instruction.
// Optional build macro IMEM_PARITY_EN: adds an even-parity bit per word and
// reports fault 2'b11 on a stored-parity mismatch.
module instr_mem_fetch #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] RESET_WORD  = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    instr_mem_fetch_if.slave   bus
);

    localparam int unsigned    IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0]    SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

`ifdef IMEM_PARITY_EN
    localparam int unsigned WORD_W = 33;
`else
    localparam int unsigned WORD_W = 32;
`endif

    localparam logic [1:0] FAULT_OK     = 2'b00;
    localparam logic [1:0] FAULT_ALIGN  = 2'b01;
    localparam logic [1:0] FAULT_RANGE  = 2'b10;
    localparam logic [1:0] FAULT_PARITY = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Classify an address: misalignment wins over range. The offset from
    // BASE_ADDR is taken modulo 2^32, so addresses below the base wrap to a
    // huge offset and land in the range fault.
    function automatic logic [1:0] addr_fault(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - BASE_ADDR;
        if (addr[1:0] != 2'b00) begin
            return FAULT_ALIGN;
        end else if (offset >= SPAN_BYTES) begin
            return FAULT_RANGE;
        end else begin
            return FAULT_OK;
        end
    endfunction

    // Word index of an in-range, aligned address.
    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

`ifdef IMEM_PARITY_EN
    // Even parity bit: makes the total number of ones in {p, data} even.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

    // Stored word is consistent when the whole {p, data} vector XORs to 0.
    function automatic logic parity_ok(input logic [WORD_W-1:0] word);
        return (^word) == 1'b0;
    endfunction

    // Build the stored word from 32 data bits.
    function automatic logic [WORD_W-1:0] encode_word(input logic [31:0] data);
        return {even_parity(data), data};
    endfunction
`else
    // Without parity the stored word is the data itself.
    function automatic logic [WORD_W-1:0] encode_word(input logic [31:0] data);
        return data;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [IDX_W-1:0]    init_cnt_q,  init_cnt_d;
    logic                init_done_q, init_done_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_instr_q, rsp_instr_d;
    logic [1:0]          rsp_fault_q, rsp_fault_d;

    logic [WORD_W-1:0]   mem_q [DEPTH_WORDS];

    // Combinational controls
    logic                req_ready_s;
    logic                accept_s;
    logic                mem_we_s;
    logic [IDX_W-1:0]    mem_widx_s;
    logic [WORD_W-1:0]   mem_wdata_s;
    logic [1:0]          req_fault_s;
    logic [IDX_W-1:0]    rd_idx_s;
    logic [WORD_W-1:0]   rd_word_s;

    // State register: control flops with synchronous reset back to INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= 32'h0000_0000;
            rsp_fault_q <= FAULT_OK;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Next-state logic: walk the init index, move to RUN after the last word.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + IDX_ONE;
                if (init_cnt_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    state_d     = ST_INIT;
                    init_done_d = 1'b0;
                end
            end
            ST_RUN: begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
            default: begin
                state_d     = ST_INIT;
                init_cnt_d  = '0;
                init_done_d = 1'b0;
            end
        endcase
    end

    // FSM outputs: fetch-port ready and the single memory write port
    // (init sweep in INIT, validated program-load writes in RUN).
    always_comb begin
        req_ready_s = 1'b0;
        mem_we_s    = 1'b0;
        mem_widx_s  = '0;
        mem_wdata_s = encode_word(RESET_WORD);
        case (state_q)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_widx_s  = init_cnt_q;
                mem_wdata_s = encode_word(RESET_WORD);
            end
            ST_RUN: begin
                req_ready_s = init_done_q & (~rsp_valid_q | bus.rsp_ready);
                if (bus.prog_we && (addr_fault(bus.prog_addr) == FAULT_OK)) begin
                    mem_we_s    = 1'b1;
                    mem_widx_s  = word_index(bus.prog_addr);
                    mem_wdata_s = encode_word(bus.prog_data);
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                req_ready_s = 1'b0;
                mem_we_s    = 1'b0;
            end
        endcase
    end

    assign accept_s = bus.req_valid & req_ready_s;

    // Response path: classify the accepted pc, read the addressed word (the
    // array value before this edge's write, giving read-before-write), and
    // hold the response while it is stalled.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_instr_d = rsp_instr_q;
        rsp_fault_d = rsp_fault_q;
        req_fault_s = addr_fault(bus.req_pc);
        rd_idx_s    = word_index(bus.req_pc);
        rd_word_s   = mem_q[rd_idx_s];
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            if (req_fault_s != FAULT_OK) begin
                rsp_fault_d = req_fault_s;
                rsp_instr_d = 32'h0000_0000;
            end else begin
`ifdef IMEM_PARITY_EN
                if (!parity_ok(rd_word_s)) begin
                    rsp_fault_d = FAULT_PARITY;
                end else begin
                    rsp_fault_d = FAULT_OK;
                end
`else
                rsp_fault_d = FAULT_OK;
`endif
                rsp_instr_d = rd_word_s[31:0];
            end
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Memory array write port; no write on a reset edge.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            mem_q[mem_widx_s] <= mem_wdata_s;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.init_done = init_done_q;

endmodule
